// File: rtl/execution_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and
// emits the one-cycle write strobes for PC, IR, register bank, special register and data memory.
module execution_sequencer #(
  parameter int MEM_WAIT_CYCLES = 1,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [2:0]             controlMAH,
  input  logic                   allow_write_on_memory,
  input  logic                   should_read_from_input,
  input  logic [2:0]             controlRB,
  input  logic [2:0]             specreg_update_mode,
  input  logic                   input_confirm,
  input  logic                   resume,
  output logic                   ir_load,
  output logic                   pc_enable,
  output logic                   regbank_write,
  output logic                   specreg_write,
  output logic                   mem_write_strobe,
  output logic [2:0]             stage,
  output logic                   halted,
  output logic                   waiting_input,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MEMORY     = 3'd3,
    S_INPUT_WAIT = 3'd4,
    S_WRITEBACK  = 3'd5,
    S_HALT       = 3'd6
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES);

  state_t                 state_reg, state_next;
  logic [3:0]             wait_cnt_reg, wait_cnt_next;
  logic                   mem_reg, wr_reg, inp_reg, rb_reg, sr_reg, hlt_reg;
  logic                   confirm_prev_reg;
  logic [COUNT_WIDTH-1:0] retired_count_reg;

  logic wait_done;
  logic ir_load_comb, pc_enable_comb, regbank_write_comb, specreg_write_comb, mem_write_comb;
  logic halted_comb, waiting_input_comb;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg         <= S_FETCH;
      wait_cnt_reg      <= 4'd0;
      mem_reg           <= 1'b0;
      wr_reg            <= 1'b0;
      inp_reg           <= 1'b0;
      rb_reg            <= 1'b0;
      sr_reg            <= 1'b0;
      hlt_reg           <= 1'b0;
      confirm_prev_reg  <= 1'b0;
      retired_count_reg <= '0;
    end else begin
      state_reg        <= state_next;
      wait_cnt_reg     <= wait_cnt_next;
      confirm_prev_reg <= input_confirm;
      // Control-core fields are only trusted while the instruction is being decoded.
      if (state_reg == S_DECODE) begin
        mem_reg <= (controlMAH != 3'd0) | allow_write_on_memory;
        wr_reg  <= allow_write_on_memory;
        inp_reg <= should_read_from_input;
        rb_reg  <= (controlRB != 3'd0);
        sr_reg  <= (specreg_update_mode != 3'd0);
        hlt_reg <= ~enable;
      end
      if (state_reg == S_WRITEBACK) begin
        retired_count_reg <= retired_count_reg + COUNT_WIDTH'(1);
      end
    end
  end

  assign wait_done = (wait_cnt_reg == WAIT_LAST);

  always_comb begin
    state_next         = state_reg;
    wait_cnt_next      = wait_cnt_reg;
    ir_load_comb       = 1'b0;
    pc_enable_comb     = 1'b0;
    regbank_write_comb = 1'b0;
    specreg_write_comb = 1'b0;
    mem_write_comb     = 1'b0;
    halted_comb        = 1'b0;
    waiting_input_comb = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (wait_done) begin
          ir_load_comb = 1'b1;
          state_next   = S_DECODE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        if (inp_reg)      state_next = S_INPUT_WAIT;
        else if (mem_reg) state_next = S_MEMORY;
        else              state_next = S_WRITEBACK;
      end
      S_MEMORY: begin
        mem_write_comb = wr_reg && (wait_cnt_reg == 4'd0);
        if (wait_done) state_next    = S_WRITEBACK;
        else           wait_cnt_next = wait_cnt_reg + 4'd1;
      end
      S_INPUT_WAIT: begin
        waiting_input_comb = 1'b1;
        if (input_confirm && !confirm_prev_reg) state_next = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        regbank_write_comb = rb_reg;
        specreg_write_comb = sr_reg;
        pc_enable_comb     = ~hlt_reg;
        state_next         = hlt_reg ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted_comb = 1'b1;
        if (resume) begin
          pc_enable_comb = 1'b1;
          state_next     = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
    if (state_next != state_reg) wait_cnt_next = 4'd0;
  end

  // Reset forces strobes low even when a zero-wait FETCH would otherwise assert ir_load.
  assign ir_load          = ir_load_comb & reset;
  assign pc_enable        = pc_enable_comb & reset;
  assign regbank_write    = regbank_write_comb & reset;
  assign specreg_write    = specreg_write_comb & reset;
  assign mem_write_strobe = mem_write_comb & reset;
  assign halted           = halted_comb & reset;
  assign waiting_input    = waiting_input_comb & reset;
  assign stage            = state_reg;
  assign retired_count    = retired_count_reg;

endmodule

// File: tb/tb_execution_sequencer.sv
// Randomized scoreboard bench for execution_sequencer: each issued instruction pushes its
// expected timing and strobes; a negedge monitor pops and compares at every WRITEBACK / HALT exit.
module tb_execution_sequencer;

  localparam int W  = 1;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic [2:0]    controlMAH = 3'd0;
  logic          allow_write_on_memory = 1'b0;
  logic          should_read_from_input = 1'b0;
  logic [2:0]    controlRB = 3'd0;
  logic [2:0]    specreg_update_mode = 3'd0;
  logic          input_confirm = 1'b0;
  logic          resume = 1'b0;
  logic          ir_load, pc_enable, regbank_write, specreg_write, mem_write_strobe;
  logic [2:0]    stage;
  logic          halted, waiting_input;
  logic [CW-1:0] retired_count;

  execution_sequencer #(.MEM_WAIT_CYCLES(W), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .controlMAH(controlMAH),
    .allow_write_on_memory(allow_write_on_memory), .should_read_from_input(should_read_from_input),
    .controlRB(controlRB), .specreg_update_mode(specreg_update_mode),
    .input_confirm(input_confirm), .resume(resume),
    .ir_load(ir_load), .pc_enable(pc_enable), .regbank_write(regbank_write),
    .specreg_write(specreg_write), .mem_write_strobe(mem_write_strobe), .stage(stage),
    .halted(halted), .waiting_input(waiting_input), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int dur;
    int ir_idx;
    int mw_idx;
    bit rb;
    bit sr;
    bit pce;
    int retired_before;
  } exp_t;

  exp_t sb_q[$];
  int   halt_q[$];
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0, ir_cnt = 0, ir_idx = 0, mw_cnt = 0, mw_idx = 0, halt_cyc = 0;
  int   done_cnt = 0, issued = 0, model_retired = 0;
  exp_t mon_e;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_monitor();
    cyc = 0; ir_cnt = 0; ir_idx = 0; mw_cnt = 0; mw_idx = 0; halt_cyc = 0;
  endtask

  // Monitor: per-cycle invariants plus scoreboard pops on WRITEBACK and on HALT exit.
  always @(negedge clock) begin
    if (mon_en) begin
      check("ir_and_mw_same_cycle", ir_load & mem_write_strobe, 0);
      check("halted_flag", halted, stage == 3'd6);
      check("waiting_flag", waiting_input, stage == 3'd4);
      if (stage == 3'd6) begin
        halt_cyc++;
        check("halt_strobes", {ir_load, regbank_write, specreg_write, mem_write_strobe}, 0);
        if (pc_enable) begin
          if (halt_q.size() == 0) check("halt_exit_unexpected", 1, 0);
          else check("halt_cycles", halt_cyc, halt_q.pop_front());
          halt_cyc = 0;
        end
      end else begin
        cyc++;
        if (ir_load) begin ir_cnt++; ir_idx = cyc; end
        if (mem_write_strobe) begin mw_cnt++; mw_idx = cyc; end
        if (stage != 3'd5) begin
          check("strobe_outside_wb", {regbank_write, specreg_write, pc_enable}, 0);
        end else begin
          if (sb_q.size() == 0) begin
            check("wb_unexpected", 1, 0);
          end else begin
            mon_e = sb_q.pop_front();
            check("instr_cycles", cyc, mon_e.dur);
            check("ir_load_count", ir_cnt, 1);
            check("ir_load_cycle", ir_idx, mon_e.ir_idx);
            check("mem_write_count", mw_cnt, (mon_e.mw_idx != 0) ? 1 : 0);
            if (mon_e.mw_idx != 0) check("mem_write_cycle", mw_idx, mon_e.mw_idx);
            check("regbank_write", regbank_write, mon_e.rb);
            check("specreg_write", specreg_write, mon_e.sr);
            check("wb_pc_enable", pc_enable, mon_e.pce);
            check("retired_count", retired_count, mon_e.retired_before);
          end
          done_cnt++;
          cyc = 0; ir_cnt = 0; ir_idx = 0; mw_cnt = 0; mw_idx = 0;
        end
      end
    end
  end

  task automatic wait_stage(input int s, input string name);
    int n = 0;
    while (stage != 3'(s) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (stage != 3'(s)) begin
      failures++;
      checks++;
      $display("FAIL timeout_%s actual_stage=%0d expected_stage=%0d", name, stage, s);
      $fatal(1, "wait bound expired");
    end
  endtask

  // kind: 0 ALU, 1 store, 2 INSW held high on entry, 3 halt, otherwise fully random.
  // Called at the first FETCH cycle; returns at the first FETCH cycle of the next instruction.
  task automatic issue(input int kind);
    logic [2:0] mah, rbs, srm;
    logic       aw, inp, en, pre;
    int         h, d, hw;
    bit         mem;
    exp_t       e;
    mah = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    aw  = ($urandom_range(0, 3) == 0);
    inp = ($urandom_range(0, 4) == 0);
    rbs = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    srm = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    en  = ($urandom_range(0, 5) != 0);
    pre = 1'($urandom_range(0, 1));
    case (kind)
      0: begin mah = 3'd0; aw = 1'b0; inp = 1'b0; rbs = 3'd1; srm = 3'd2; en = 1'b1; end
      1: begin mah = 3'd5; aw = 1'b1; inp = 1'b0; rbs = 3'd0; en = 1'b1; end
      2: begin inp = 1'b1; pre = 1'b1; rbs = 3'd1; en = 1'b1; end
      3: begin en = 1'b0; inp = 1'b0; end
      default: ;
    endcase
    h  = $urandom_range(0, 3);
    d  = $urandom_range(0, 3);
    hw = (kind == 3) ? 9 : $urandom_range(0, 6);
    mem = (mah != 3'd0) || aw;
    e.dur = inp ? (4 + W + h + d + 2) : (mem ? (5 + 2 * W) : (4 + W));
    e.ir_idx = 1 + W;
    e.mw_idx = (!inp && mem && aw) ? (4 + W) : 0;
    e.rb = (rbs != 3'd0);
    e.sr = (srm != 3'd0);
    e.pce = en;
    e.retired_before = model_retired;
    model_retired = (model_retired + 1) % (1 << CW);
    sb_q.push_back(e);
    if (!en) halt_q.push_back(hw + 1);
    issued++;

    controlMAH = mah; allow_write_on_memory = aw; should_read_from_input = inp;
    controlRB = rbs; specreg_update_mode = srm; enable = en;
    input_confirm = inp ? pre : 1'($urandom_range(0, 1));
    wait_stage(1, "decode");
    @(posedge clock); #1;
    // Fields are latched by now; garbage afterwards must not matter.
    controlMAH = 3'($urandom); allow_write_on_memory = 1'($urandom);
    should_read_from_input = 1'($urandom); controlRB = 3'($urandom);
    specreg_update_mode = 3'($urandom); enable = 1'($urandom);
    if (inp) begin
      wait_stage(4, "input_wait");
      repeat (h) begin @(posedge clock); #1; end
      input_confirm = 1'b0;
      repeat (d + 1) begin @(posedge clock); #1; end
      input_confirm = 1'b1;
    end
    wait_stage(5, "writeback");
    @(posedge clock); #1;
    if (!en) begin
      wait_stage(6, "halt");
      repeat (hw) begin
        input_confirm = 1'($urandom);
        @(posedge clock); #1;
      end
      resume = 1'b1;
      @(posedge clock); #1;
      resume = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_stage", stage, 0);
    check("reset_retired", retired_count, 0);
    check("reset_strobes", {ir_load, pc_enable, regbank_write, specreg_write, mem_write_strobe}, 0);
    check("reset_flags", {halted, waiting_input}, 0);
    reset = 1'b1;
    clear_monitor();
    mon_en = 1'b1;

    issue(0);
    issue(1);
    issue(2);
    issue(3);
    for (int i = 0; i < 40; i++) issue(-1);

    // Reset asserted in the first MEMORY cycle of a store; that instruction never retires.
    mon_en = 1'b0;
    controlMAH = 3'd5; allow_write_on_memory = 1'b1; should_read_from_input = 1'b0;
    controlRB = 3'd0; specreg_update_mode = 3'd0; enable = 1'b1;
    wait_stage(3, "memory");
    check("store_strobe_before_reset", mem_write_strobe, 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_stage", stage, 0);
    check("async_reset_strobes", {ir_load, pc_enable, regbank_write, specreg_write, mem_write_strobe}, 0);
    check("async_reset_retired", retired_count, 0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_hold_mem_write", mem_write_strobe, 0);
    reset = 1'b1;
    check("release_stage", stage, 0);
    check("release_retired", retired_count, 0);
    sb_q.delete();
    halt_q.delete();
    model_retired = 0;
    clear_monitor();
    mon_en = 1'b1;

    issue(0);
    for (int i = 0; i < 20; i++) issue(-1);
    issue(3);

    mon_en = 1'b0;
    check("scoreboard_empty", sb_q.size(), 0);
    check("halt_queue_empty", halt_q.size(), 0);
    check("retired_total", done_cnt, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
